// File: rtl/bcd_subtractor_serial.sv
// bcd_subtractor_serial
//   Digit-serial packed-BCD subtractor: D = A - B - Bin, one decimal digit per
//   clock, least-significant digit first. A negative result comes back in
//   ten's-complement form with Bout=1.
//
//   Optional feature macro: BCD_SUB_CHECK_EN
//     defined   -> every A/B digit is range-checked as it is processed; err is
//                  sticky until the next accepted start or rst.
//     undefined -> no checking logic; err is tied low.
//
// Parameters
//   DIGITS  number of BCD digits per operand (1..16)
//
// Ports
//   clk    clock, rising edge
//   rst    synchronous active-high reset
//   start  launch request, honoured only when idle or in the done cycle
//   A      minuend, packed BCD, digit 0 in [3:0]
//   B      subtrahend, packed BCD
//   Bin    borrow in at digit 0
//   D      registered difference, packed BCD
//   Bout   registered borrow out of the top digit (1 = A < B + Bin)
//   busy   high while digits are being processed
//   done   one-cycle pulse when D/Bout are fresh
//   err    invalid-digit flag (valid with done)

module bcd_subtractor_serial #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   A,
    input  logic [4*DIGITS-1:0]   B,
    input  logic                  Bin,
    output logic [4*DIGITS-1:0]   D,
    output logic                  Bout,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int W  = 4 * DIGITS;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t          state_reg;
    logic [W-1:0]    a_sh_reg;
    logic [W-1:0]    b_sh_reg;
    logic [W-1:0]    res_reg;
    logic [IW-1:0]   idx_reg;
    logic            borrow_reg;
    logic [W-1:0]    d_reg;
    logic            bout_reg;
    logic            busy_reg;
    logic            done_reg;

    // Per-digit datapath on the current low digit of the operand shifters.
    logic [4:0]      t_next;
    logic            borrow_next;
    logic [3:0]      digit_next;
    logic [W+3:0]    cat_next;
    logic [W-1:0]    res_next;

    always_comb begin
        // 5-bit two's-complement difference; bit 4 is the sign.
        t_next      = {1'b0, a_sh_reg[3:0]} - {1'b0, b_sh_reg[3:0]} - {4'b0000, borrow_reg};
        borrow_next = t_next[4];
        // Adding 10 modulo 16 to the low nibble recovers the decimal digit.
        digit_next  = borrow_next ? (t_next[3:0] + 4'd10) : t_next[3:0];
        // New digit enters at the MSD end; after DIGITS shifts digit 0 sits in [3:0].
        // The widened concatenation keeps this legal when DIGITS == 1.
        cat_next    = {digit_next, res_reg};
        res_next    = cat_next[W+3:4];
    end

`ifdef BCD_SUB_CHECK_EN
    logic err_reg;
    logic digit_bad;

    always_comb begin
        digit_bad = (a_sh_reg[3:0] > 4'd9) || (b_sh_reg[3:0] > 4'd9);
    end

    assign err = err_reg;
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= ST_IDLE;
            a_sh_reg   <= '0;
            b_sh_reg   <= '0;
            res_reg    <= '0;
            idx_reg    <= '0;
            borrow_reg <= 1'b0;
            d_reg      <= '0;
            bout_reg   <= 1'b0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
`ifdef BCD_SUB_CHECK_EN
            err_reg    <= 1'b0;
`endif
        end else begin
            case (state_reg)
                ST_IDLE, ST_DONE: begin
                    done_reg <= 1'b0;
                    if (start) begin
                        a_sh_reg   <= A;
                        b_sh_reg   <= B;
                        borrow_reg <= Bin;
                        idx_reg    <= '0;
                        busy_reg   <= 1'b1;
                        state_reg  <= ST_RUN;
`ifdef BCD_SUB_CHECK_EN
                        err_reg    <= 1'b0;
`endif
                    end else begin
                        busy_reg   <= 1'b0;
                        state_reg  <= ST_IDLE;
                    end
                end

                ST_RUN: begin
                    // start is deliberately not looked at here.
                    a_sh_reg   <= a_sh_reg >> 4;
                    b_sh_reg   <= b_sh_reg >> 4;
                    res_reg    <= res_next;
                    borrow_reg <= borrow_next;
                    idx_reg    <= idx_reg + 1'b1;
`ifdef BCD_SUB_CHECK_EN
                    if (digit_bad) begin
                        err_reg <= 1'b1;
                    end
`endif
                    if (idx_reg == IDX_LAST) begin
                        d_reg     <= res_next;
                        bout_reg  <= borrow_next;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                        state_reg <= ST_DONE;
                    end
                end

                default: begin
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign D    = d_reg;
    assign Bout = bout_reg;
    assign busy = busy_reg;
    assign done = done_reg;

endmodule

// File: tb/tb_bcd_subtractor_serial.sv
// tb_bcd_subtractor_serial
//   Self-checking bench for bcd_subtractor_serial (DIGITS=4). An integer-level
//   model tracks operation timing and results; a negedge process compares the
//   DUT outputs against it every cycle. Directed cases carry literal
//   expectations that pin the model itself.

module tb_bcd_subtractor_serial;

    logic        clk   = 1'b0;
    logic        rst   = 1'b1;
    logic        start = 1'b0;
    logic [15:0] A     = '0;
    logic [15:0] B     = '0;
    logic        Bin   = 1'b0;
    logic [15:0] D;
    logic        Bout;
    logic        busy;
    logic        done;
    logic        err;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    bcd_subtractor_serial #(.DIGITS(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
        .Bin   (Bin),
        .D     (D),
        .Bout  (Bout),
        .busy  (busy),
        .done  (done),
        .err   (err)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic int bcd2int(input logic [15:0] v);
        int r;
        r = 0;
        for (int i = 3; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
        return r;
    endfunction

    function automatic logic [15:0] int2bcd(input int v);
        logic [15:0] r;
        int x;
        x = v;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic has_bad(input logic [15:0] v);
        for (int i = 0; i < 4; i++) if (v[4*i +: 4] > 4'd9) return 1'b1;
        return 1'b0;
    endfunction

    // ---------------- reference model (timing + arithmetic) ----------------
    int          cyc = 0;        // number of rising edges seen
    int          n0 = 0;         // edge at which the current op was accepted
    bit          active = 0;
    logic [15:0] exp_d = '0;
    logic        exp_b = 1'b0;
    bit          dvalid = 1;
    bit          exp_err = 0;
    logic [15:0] pend_d = '0;
    logic        pend_b = 1'b0;
    bit          pend_valid = 1;
    bit          pend_err = 0;
    bit          rst_last = 0;
    int          diff;

    always @(posedge clk) begin
        cyc++;
        rst_last = rst;
        if (rst) begin
            active = 0;
            exp_d  = '0;
            exp_b  = 1'b0;
            dvalid = 1;
        end else begin
            if (active && cyc == n0 + 4) begin
                exp_d   = pend_d;
                exp_b   = pend_b;
                dvalid  = pend_valid;
                exp_err = pend_err;
            end
            if (start && (!active || cyc >= n0 + 5)) begin
                diff   = bcd2int(A) - bcd2int(B) - int'(Bin);
                pend_b = (diff < 0);
                if (diff < 0) diff = diff + 10000;
                pend_d     = int2bcd(diff);
                pend_err   = has_bad(A) || has_bad(B);
                pend_valid = !pend_err;
                n0     = cyc;
                active = 1;
            end
        end
    end

    logic exp_busy, exp_done;

    always @(negedge clk) begin
        if (cyc > 0) begin
            exp_busy = active && (cyc >= n0) && (cyc <= n0 + 3);
            exp_done = active && (cyc == n0 + 4);
            chk("busy", busy, exp_busy);
            chk("done", done, exp_done);
            if (dvalid) begin
                chk("D", D, exp_d);
                chk("Bout", Bout, exp_b);
            end
`ifdef BCD_SUB_CHECK_EN
            if (exp_done) chk("err@done", err, exp_err);
            else if (rst_last) chk("err@rst", err, 0);
`else
            chk("err", err, 0);
`endif
        end
    end

    // ---------------- stimulus ----------------
    task automatic launch(input logic [15:0] a, input logic [15:0] b, input logic bin);
        @(negedge clk);
        A = a; B = b; Bin = bin; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called at the negedge just after the accepting edge.
    task automatic wait_done(output int lat, output int bc);
        lat = 1;
        bc  = busy ? 1 : 0;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
            if (busy) bc++;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL timeout: no done after %0d cycles", lat);
        end
    endtask

    task automatic op_lit(input string nm, input logic [15:0] a, input logic [15:0] b,
                          input logic bin, input logic [15:0] ed, input logic eb);
        int lat, bc;
        launch(a, b, bin);
        wait_done(lat, bc);
        chk({nm, " latency"}, lat, 5);
        chk({nm, " busy cycles"}, bc, 4);
        chk({nm, " D"}, D, ed);
        chk({nm, " Bout"}, Bout, eb);
        $display("op %s: %h - %h - %0d -> D=%h Bout=%0d lat=%0d", nm, a, b, bin, D, Bout, lat);
    endtask

    task automatic count_done(input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (done) cnt++;
        end
    endtask

    initial begin
        int lat, bc, cnt;
        logic [15:0] ra, rb;
        logic        rbin;

        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset D", D, 0);
        chk("reset Bout", Bout, 0);
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset err", err, 0);
        rst = 1'b0;

        op_lit("basic",  16'h0042, 16'h0017, 1'b0, 16'h0025, 1'b0);
        op_lit("wrap0",  16'h0000, 16'h0001, 1'b0, 16'h9999, 1'b1);
        op_lit("wrap9",  16'h9999, 16'h9999, 1'b1, 16'h9999, 1'b1);
        op_lit("1000-1", 16'h1000, 16'h0001, 1'b0, 16'h0999, 1'b0);

        // Second start mid-RUN with different operands must be ignored.
        launch(16'h0042, 16'h0017, 1'b0);
        @(negedge clk);
        A = 16'h5555; B = 16'h1111; Bin = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(lat, bc);
        chk("midstart D", D, 16'h0025);
        chk("midstart Bout", Bout, 0);
        $display("op midstart: ignored start, D=%h Bout=%0d", D, Bout);
        count_done(7, cnt);
        chk("midstart extra done", cnt, 0);

        // Back-to-back: start held through the DONE cycle.
        @(negedge clk);
        A = 16'h0500; B = 16'h0123; Bin = 1'b0; start = 1'b1;
        @(negedge clk);
        wait_done(lat, bc);
        chk("b2b first D", D, 16'h0377);
        A = 16'h0001; B = 16'h0002; Bin = 1'b0;
        @(negedge clk);
        start = 1'b0;
        wait_done(lat, bc);
        chk("b2b spacing", lat, 5);
        chk("b2b second D", D, 16'h9999);
        chk("b2b second Bout", Bout, 1);
        $display("op b2b: second D=%h Bout=%0d spacing=%0d", D, Bout, lat);

        // Reset on the second RUN cycle.
        launch(16'h0042, 16'h0017, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort D", D, 0);
        chk("abort busy", busy, 0);
        chk("abort done", done, 0);
        rst = 1'b0;
        count_done(8, cnt);
        chk("abort no done", cnt, 0);
        $display("op abort: D=%h busy=%0d", D, busy);

        // Invalid digit handling.
        launch(16'h00A0, 16'h0000, 1'b0);
        wait_done(lat, bc);
`ifdef BCD_SUB_CHECK_EN
        chk("invalid err", err, 1);
`else
        chk("invalid err off", err, 0);
`endif
        $display("op invalid: err=%0d", err);
        op_lit("after-invalid", 16'h0010, 16'h0003, 1'b0, 16'h0007, 1'b0);
        chk("err cleared", err, 0);

        // Randomized sweep, checked by the model.
        for (int i = 0; i < 1000; i++) begin
            for (int k = 0; k < 4; k++) begin
                ra[4*k +: 4] = 4'($urandom_range(9, 0));
                rb[4*k +: 4] = 4'($urandom_range(9, 0));
            end
            rbin = 1'($urandom_range(1, 0));
            launch(ra, rb, rbin);
            wait_done(lat, bc);
            $display("op rnd%0d: %h - %h - %0d -> D=%h Bout=%0d", i, ra, rb, rbin, D, Bout);
        end

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bcd_subtractor_serial.md
# bcd_subtractor_serial

Digit-serial multi-digit BCD subtractor: computes D = A − B − Bin on packed BCD operands, one decimal digit per clock, least-significant digit first. It is the inverse-operation companion to the combinational BCD adder. It sits beside the adder in the decimal arithmetic datapath and is controlled by a start/busy/done handshake. A borrow out marks a negative result, with D returned in ten's-complement form.

## Interface

Parameters:
- DIGITS, default 4: number of BCD digits per operand; legal range 1–16.

Ports:
- clk  input  1  sole clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE or DONE.
- A  input  4*DIGITS  minuend, packed BCD, digit 0 in bits [3:0].
- B  input  4*DIGITS  subtrahend, packed BCD.
- Bin  input  1  borrow in, applied at digit 0.
- D  output  4*DIGITS  difference, packed BCD; registered.
- Bout  output  1  borrow out of the most significant digit; 1 means A < B + Bin.
- busy  output  1  high while digits are being processed.
- done  output  1  one-cycle pulse when D and Bout are valid.
- err  output  1  invalid-digit flag; see Configuration.

## Operation

- States:
  - IDLE: busy=0.
  - RUN: busy=1; a digit index counter idx runs 0..DIGITS-1.
  - DONE: done=1 for exactly one cycle.
- IDLE or DONE with start=1:
  - latch A, B and Bin into internal shift registers;
  - set the borrow register to Bin, idx=0, err=0;
  - go to RUN.
- DONE with start=0: go to IDLE.
- RUN, each cycle, working on digit idx:
  - t = a_idx − b_idx − borrow, computed in 5-bit signed arithmetic;
  - if t < 0, the digit result is t + 10 and borrow becomes 1;
  - otherwise the digit result is t and borrow becomes 0;
  - shift the digit result into the result register from the MSD end;
  - increment idx.
- RUN after digit DIGITS-1: go to DONE. D and Bout are updated on that same edge.
- D and Bout hold their values until the next accepted start completes. They are not cleared at start.
- start while in RUN is ignored, with no effect on the operation in flight. Operands are not re-latched.
- Negative result: D = 10^DIGITS + A − B − Bin and Bout=1. For example, 0000 − 0001 gives 9999 with Bout=1.

## Timing

- Reset values: D=0, Bout=0, busy=0, done=0, err=0, state IDLE.
- rst wins over every other input on the same edge.
- rst in RUN or DONE aborts the operation. The partial result is discarded and outputs return to reset values on the next edge.
- start is accepted at edge N:
  - busy=1 from N through N+DIGITS−1;
  - done=1 and D/Bout valid in the cycle following edge N+DIGITS;
  - latency is DIGITS+1 cycles from the start edge to the done pulse.
- Back-to-back operation: start held high during the DONE cycle launches the next operation. busy rises on the edge where done falls.
- Throughput: one operation per DIGITS+1 cycles.
- A, B and Bin need to be stable only at the accepting edge.

## Configuration

- Macro: BCD_SUB_CHECK_EN.
- Defined:
  - each digit of A and B is checked on the cycle that digit is processed;
  - any digit > 9 sets err, which is sticky until the next accepted start or rst;
  - err is valid with done;
  - arithmetic proceeds unchanged, and D is unspecified when err=1.
- Undefined:
  - no checking logic is generated;
  - err is tied to 0;
  - D for invalid input digits is unspecified.

## Test plan

All scenarios use DIGITS=4.
- Basic: A=0x0042, B=0x0017, Bin=0. Expect D=0x0025, Bout=0, done exactly 5 cycles after start, busy high for 4 cycles.
- Borrow wrap: A=0x0000, B=0x0001 → D=0x9999, Bout=1. A=0x9999, B=0x9999, Bin=1 → D=0x9999, Bout=1. A=0x1000, B=0x0001 → D=0x0999, Bout=0.
- Handshake:
  - a second start mid-RUN, with different operands, is ignored and the first result is delivered;
  - start held through DONE gives back-to-back results with done pulses 5 cycles apart.
- Reset mid-operation: rst asserted on the 2nd RUN cycle. Next cycle shows D=0, busy=0, done=0, with no done pulse afterwards.
- Validity check, with BCD_SUB_CHECK_EN defined: A=0x00A0, B=0x0000 → err=1 at done. A following valid operation clears err to 0. With the macro undefined, err stays 0.
- Randomized sweep: 1000 valid operand pairs compared against an integer model. D must equal (A−B−Bin) mod 10^4 in BCD, and Bout must equal (A < B+Bin).
